// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes a 32-bit hex value onto one shared
// seven-segment bus, one digit per refresh slot, eight slots per frame.
// Display data is double-buffered: a load lands in a pending register and
// is copied into the shadow register that drives the segments only at a
// frame wrap. A scan therefore never mixes old and new data.
//
// Load protocol: 'load' is a one-cycle strobe with no back-pressure. Every
// cycle with load=1 overwrites the pending data, so the last strobe before a
// frame wrap wins.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  dp_mask,
    input  logic        blank_lz,
    input  logic        load,
    input  logic        enable,
    output logic [2:0]  select,
    output logic        led_enable,
    output logic [7:0]  seg,
    output logic        frame_done
);

    // REFRESH_DIV is at least 2, so PW is at least 1 and holds REFRESH_DIV-1.
    localparam int            PW         = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic          en_q;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    sel_q, sel_d;
    logic          fd_q, fd_d;

    logic [31:0]   pend_val_q, pend_val_d;
    logic [7:0]    pend_dp_q, pend_dp_d;
    logic          pend_blz_q, pend_blz_d;
    logic          pend_flag_q, pend_flag_d;

    logic [31:0]   sh_val_q, sh_val_d;
    logic [7:0]    sh_dp_q, sh_dp_d;
    logic          sh_blz_q, sh_blz_d;

    logic          tick;
    logic          wrap;
    logic          commit;

    // A slot ends on tick; the last slot of a frame ending is a wrap.
    assign tick   = en_q && (presc_q == PRESC_LAST);
    assign wrap   = tick && (sel_q == 3'd7);
    assign commit = wrap && pend_flag_q;

    // Next-state logic: scan counters advance only while enabled; the
    // commit reads the pending contents from before this edge, so a load on
    // the same edge stays pending for the following frame.
    always_comb begin
        presc_d     = presc_q;
        sel_d       = sel_q;
        fd_d        = wrap;
        pend_val_d  = pend_val_q;
        pend_dp_d   = pend_dp_q;
        pend_blz_d  = pend_blz_q;
        pend_flag_d = pend_flag_q;
        sh_val_d    = sh_val_q;
        sh_dp_d     = sh_dp_q;
        sh_blz_d    = sh_blz_q;

        if (en_q) begin
            if (tick) begin
                presc_d = '0;
                sel_d   = sel_q + 3'd1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (commit) begin
            sh_val_d    = pend_val_q;
            sh_dp_d     = pend_dp_q;
            sh_blz_d    = pend_blz_q;
            pend_flag_d = 1'b0;
        end

        if (load) begin
            pend_val_d  = value;
            pend_dp_d   = dp_mask;
            pend_blz_d  = blank_lz;
            pend_flag_d = 1'b1;
        end
    end

    // State registers with synchronous reset; reset also drops any pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q        <= 1'b0;
            presc_q     <= '0;
            sel_q       <= 3'd0;
            fd_q        <= 1'b0;
            pend_val_q  <= 32'd0;
            pend_dp_q   <= 8'd0;
            pend_blz_q  <= 1'b0;
            pend_flag_q <= 1'b0;
            sh_val_q    <= 32'd0;
            sh_dp_q     <= 8'd0;
            sh_blz_q    <= 1'b0;
        end else begin
            en_q        <= enable;
            presc_q     <= presc_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
            pend_val_q  <= pend_val_d;
            pend_dp_q   <= pend_dp_d;
            pend_blz_q  <= pend_blz_d;
            pend_flag_q <= pend_flag_d;
            sh_val_q    <= sh_val_d;
            sh_dp_q     <= sh_dp_d;
            sh_blz_q    <= sh_blz_d;
        end
    end

    // zero_from[i] is set when shadow nibbles 7 down to i are all zero.
    logic [7:0] zero_from;

    // Build the leading-zero chain from the most significant digit downward.
    always_comb begin
        zero_from    = '0;
        zero_from[7] = (sh_val_q[31:28] == 4'd0);
        for (int i = 6; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (sh_val_q[4*i +: 4] == 4'd0);
        end
    end

    logic [3:0] nib;
    logic [6:0] hex_code;
    logic       blank_digit;

    // Hex to active-low {g,f,e,d,c,b,a} for the digit currently selected.
    always_comb begin
        nib = sh_val_q[{sel_q, 2'b00} +: 4];
        case (nib)
            4'h0:    hex_code = 7'h40;
            4'h1:    hex_code = 7'h79;
            4'h2:    hex_code = 7'h24;
            4'h3:    hex_code = 7'h30;
            4'h4:    hex_code = 7'h19;
            4'h5:    hex_code = 7'h12;
            4'h6:    hex_code = 7'h02;
            4'h7:    hex_code = 7'h78;
            4'h8:    hex_code = 7'h00;
            4'h9:    hex_code = 7'h10;
            4'hA:    hex_code = 7'h08;
            4'hB:    hex_code = 7'h03;
            4'hC:    hex_code = 7'h46;
            4'hD:    hex_code = 7'h21;
            4'hE:    hex_code = 7'h06;
            default: hex_code = 7'h0E;
        endcase
    end

    // Digit 0 is never blanked so an all-zero value still shows one "0".
    assign blank_digit = sh_blz_q && (sel_q != 3'd0) && zero_from[sel_q];

    // Segment bus: dark while disabled or blanked, otherwise dp plus hex code.
    always_comb begin
        if (!en_q || blank_digit) begin
            seg = 8'hFF;
        end else begin
            seg = {~sh_dp_q[sel_q], hex_code};
        end
    end

    assign select     = sel_q;
    assign led_enable = en_q;
    assign frame_done = fd_q;

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Upstream driver for the seven-segment digit-enable encoder.
- Time-multiplexes a 32-bit value (8 hex digits) onto one shared segment bus.
- Each digit is refreshed in turn; the block produces the 3-bit digit index and enable that the encoder turns into one-hot active-low anodes.
- New display values are double-buffered and committed only at frame boundaries, so a digit scan never mixes old and new data.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit, 125 Hz per frame); legal range 2..2^24.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- value  input  32  hex value to display; nibble i maps to digit i
- dp_mask  input  8  decimal-point enables, bit i for digit i
- blank_lz  input  1  leading-zero blanking request
- load  input  1  one-cycle strobe; captures value, dp_mask and blank_lz
- enable  input  1  display enable
- select  output  3  digit index currently driven
- led_enable  output  1  digit-enable request to the encoder
- seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}
- frame_done  output  1  one-cycle pulse at each frame wrap

Behaviour:
- Reset (synchronous, rst=1 sampled at clk edge):
  - prescaler=0, select=0, en_q=0
  - shadow and pending registers cleared (value 0, dp 0, blank_lz 0)
  - pending_flag=0, frame_done=0
  - resulting outputs: led_enable=0, seg=8'hFF
  - reset mid-frame discards any pending load.
- Enable: en_q<=enable every cycle (one-cycle latency); led_enable=en_q.
  - en_q=0: seg=8'hFF; prescaler, select and commit logic hold (frozen).
  - Scanning resumes from the held state.
- Prescaler counts 0..REFRESH_DIV-1 while en_q=1.
  - tick = (prescaler==REFRESH_DIV-1); prescaler wraps to 0 on tick.
- Digit advance: on tick, select<=select+1 (mod 8, 7 wraps to 0).
- Frame wrap: a tick with select==7.
  - frame_done=1 for exactly that cycle (registered, asserted the cycle after the wrapping edge, aligned with select=0).
- Load: on load=1, pending<=inputs and pending_flag<=1. Back-to-back loads keep the last one.
- Commit: on a frame-wrap tick with pending_flag=1 (value before the edge), shadow<=pending and pending_flag<=0.
  - Load on the same edge as a commit: the commit uses the old pending contents; the new data is written to pending and pending_flag stays 1, committing on the next frame.
  - Load on a wrap edge when pending_flag=0: nothing commits this frame; the data commits on the next wrap.
- Segment decode: combinational from registered select, shadow and en_q only; no input-to-output combinational path. Active-low hex codes (bit 7 = 1):
  - 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8
  - 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E
  - seg[7]=~shadow_dp[select].
- Leading-zero blanking: when shadow_blank_lz=1, digit i (i≥1) is blank if nibbles 7..i are all zero. A blank digit gives seg=8'hFF, dp included.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- select, led_enable, seg and frame_done are stable for the full slot. select and seg change on the same edge.

Test Plan:
- Reset values: REFRESH_DIV=4, hold rst 3 cycles with enable=1 -> select=0, led_enable=0, seg=FF, frame_done=0 during rst; led_enable=1 one cycle after release; first advance to select=1 four cycles later.
- Full scan: load value=32'h89ABCDEF, dp_mask=0, blank_lz=0; after the first wrap, check slots 0..7 -> seg=8E,86,A1,C6,83,88,90,80; each slot lasts 4 cycles; frame_done pulses once per 32 cycles.
- Tear-free update: load 32'h11111111 while select=3 -> digits 3..7 still show the old value; new value appears from select=0 of the next frame.
- Simultaneous load and wrap with pending_flag=1: old pending commits; the new data commits exactly one frame (32 cycles) later. Two consecutive loads in one frame -> only the second is displayed.
- Blanking and dp: load value=32'h00000A05, blank_lz=1, dp_mask=8'h01 -> digits 7..3 seg=FF, digit 2 88, digit 1 C0, digit 0 12; value=0 with blank_lz=1 -> digit 0 C0, all others FF.
- Enable freeze: drop enable at select=5, prescaler=2 for 10 cycles -> led_enable=0, seg=FF, select stays 5, no frame_done; restore -> resumes at prescaler=2 and completes the slot in 2 further cycles.
